// File: rtl/queue_seq_pkg.sv
// rtl/queue_seq_pkg.sv - shared types, default sizes and modular pointer arithmetic for queue_seq_ctrl
package queue_seq_pkg;

  // Burst sequencer states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  localparam int DEF_DEPTH = 1536;
  localparam int DEF_TAPS  = 1021;
  localparam int DEF_AW    = 11;

  // (a - b) mod m for a < m and b <= m; the conditional add folds a borrow back into range
  function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] m);
    logic [31:0] d;
    d = a - b;
    if (a < b) d = d + m;
    return d;
  endfunction

  // (a + b) mod m for a, b < m
  function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] m);
    logic [31:0] s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

endpackage

// File: rtl/queue_ptr_wrap.sv
// rtl/queue_ptr_wrap.sv - pointer incrementer wrapping DEPTH-1 back to 0
module queue_ptr_wrap #(
  parameter int AW    = 11,
  parameter int DEPTH = 1536
) (
  input  logic [AW-1:0] ptr_i,
  output logic [AW-1:0] ptr_o
);

  assign ptr_o = (ptr_i == AW'(DEPTH - 1)) ? '0 : ptr_i + 1'b1;

endmodule

// File: rtl/queue_seq_ctrl.sv
// rtl/queue_seq_ctrl.sv - sample RAM write pointer plus TAPS-long read burst sequencer; QSEQ_OVERRUN_EN adds sticky overrun flag
module queue_seq_ctrl
  import queue_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAPS  = DEF_TAPS,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrt_smpl,
  input  logic          dat_rdy,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          rd_en,
  output logic [AW-1:0] raddr,
  output logic          dat_vld,
  output logic          dat_first,
  output logic          dat_last,
  output logic          full,
  output logic          seq_busy,
  output logic          overrun
);

  // Fill count must reach TAPS, which may equal 2**AW
  localparam int CW = AW + 1;

  seq_state_e    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          pend_q, pend_d, pend_clr;
  logic          set_pend;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] base_q, base_d, base_new;
  logic [AW-1:0] rnext_q, rnext_d;
  logic [AW-1:0] raddr_cur, raddr_inc;
  logic          idx_zero, idx_last;
  logic          full_q, dat_vld_q, dat_first_q, dat_last_q;

  queue_ptr_wrap #(.AW(AW), .DEPTH(DEPTH)) u_wptr_wrap (
    .ptr_i (wptr_q),
    .ptr_o (wptr_nxt)
  );

  // Tap 0 reads straight from the latched base; later taps use the incremented address
  assign raddr_cur = idx_zero ? base_q : rnext_q;

  queue_ptr_wrap #(.AW(AW), .DEPTH(DEPTH)) u_raddr_wrap (
    .ptr_i (raddr_cur),
    .ptr_o (raddr_inc)
  );

  assign we       = wrt_smpl;
  assign waddr    = wptr_q;
  assign full     = full_q;
  assign dat_vld  = dat_vld_q;
  assign dat_first = dat_first_q;
  assign dat_last = dat_last_q;
  assign seq_busy = (state_q == RUN);

  assign idx_zero = (idx_q == '0);
  assign idx_last = (idx_q == AW'(TAPS - 1));

  // Oldest of the last TAPS samples, using wptr_q which already includes the triggering write
  assign base_new = AW'(mod_sub(32'(wptr_q), 32'(TAPS), 32'(DEPTH)));

  // Saturating fill count; once full every new sample requests another burst
  always_comb begin
    count_d = count_q;
    if (wrt_smpl && (count_q != CW'(TAPS))) count_d = count_q + 1'b1;
    set_pend = wrt_smpl && (count_d == CW'(TAPS));
    pend_d   = set_pend | (pend_q & ~pend_clr);
  end

  // Sequencer next state, read issue and tap index
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    base_d   = base_q;
    rnext_d  = rnext_q;
    pend_clr = 1'b0;
    rd_en    = 1'b0;
    raddr    = '0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d  = RUN;
          base_d   = base_new;
          idx_d    = '0;
          pend_clr = 1'b1;
        end
      end
      RUN: begin
        rd_en = dat_rdy;
        raddr = raddr_cur;
        if (dat_rdy) begin
          rnext_d = raddr_inc;
          if (idx_last) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; read qualifiers are delayed one cycle to line up with RAM rdata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      count_q     <= '0;
      pend_q      <= 1'b0;
      idx_q       <= '0;
      base_q      <= '0;
      rnext_q     <= '0;
      full_q      <= 1'b0;
      dat_vld_q   <= 1'b0;
      dat_first_q <= 1'b0;
      dat_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (wrt_smpl) wptr_q <= wptr_nxt;
      count_q     <= count_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      rnext_q     <= rnext_d;
      full_q      <= (count_d == CW'(TAPS));
      dat_vld_q   <= rd_en;
      dat_first_q <= rd_en & idx_zero;
      dat_last_q  <= rd_en & idx_last;
    end
  end

`ifdef QSEQ_OVERRUN_EN
  logic overrun_q;

  // A burst request arriving while one is already queued means a burst is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (set_pend && pend_q) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_queue_seq_ctrl.sv
// tb/tb_queue_seq_ctrl.sv - directed self-checking bench for queue_seq_ctrl (small and default configurations)
module tb_queue_seq_ctrl;

`ifdef QSEQ_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, wrt_smpl, dat_rdy;

  logic       s_we, s_rd_en, s_vld, s_first, s_last, s_full, s_busy, s_ovr;
  logic [3:0] s_waddr, s_raddr;
  logic        b_we, b_rd_en, b_vld, b_first, b_last, b_full, b_busy, b_ovr;
  logic [10:0] b_waddr, b_raddr;

  queue_seq_ctrl #(.DEPTH(16), .TAPS(5), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl), .dat_rdy(dat_rdy),
    .we(s_we), .waddr(s_waddr), .rd_en(s_rd_en), .raddr(s_raddr),
    .dat_vld(s_vld), .dat_first(s_first), .dat_last(s_last),
    .full(s_full), .seq_busy(s_busy), .overrun(s_ovr)
  );

  queue_seq_ctrl dut_big (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl), .dat_rdy(dat_rdy),
    .we(b_we), .waddr(b_waddr), .rd_en(b_rd_en), .raddr(b_raddr),
    .dat_vld(b_vld), .dat_first(b_first), .dat_last(b_last),
    .full(b_full), .seq_busy(b_busy), .overrun(b_ovr)
  );

  // Monitor view of whichever instance the current test targets
  logic sel = 1'b0;
  logic m_rd_en, m_vld, m_first, m_last, m_busy;
  int   m_raddr;
  assign m_rd_en = sel ? b_rd_en : s_rd_en;
  assign m_vld   = sel ? b_vld   : s_vld;
  assign m_first = sel ? b_first : s_first;
  assign m_last  = sel ? b_last  : s_last;
  assign m_busy  = sel ? b_busy  : s_busy;
  assign m_raddr = sel ? int'(b_raddr) : int'(s_raddr);

  int checks = 0;
  int failures = 0;

  int rd_q[$];
  int n_vld, n_first, n_last, first_addr, last_addr, last_pos;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wrt_smpl = 1'b0;
    dat_rdy = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      wrt_smpl = 1'b1;
      dat_rdy = 1'b1;
    end
  endtask

  // Runs until a burst sequence has been seen and the sequencer stays idle 3 cycles
  task automatic collect(input int max_cyc, input int stall_at, input int stall_len,
                         input logic [31:0] wr_mask);
    int  prev, idle, stall_left, held;
    bit  busy_seen, done_ok, stalling;
    rd_q.delete();
    n_vld = 0; n_first = 0; n_last = 0;
    first_addr = -1; last_addr = -1; last_pos = -1;
    prev = -1; idle = 0; stall_left = stall_len; held = -1;
    busy_seen = 0; done_ok = 0;
    for (int c = 0; c < max_cyc; c++) begin
      tick();
      wrt_smpl = (c < 32) && wr_mask[c[4:0]];
      stalling = (stall_left > 0) && m_busy && (rd_q.size() == stall_at);
      dat_rdy = !stalling;
      if (stalling) stall_left--;
      #1;
      if (stalling) begin
        checks++;
        if (m_rd_en !== 1'b0) begin
          failures++;
          $display("FAIL stall_rd_en: rd_en=%0b required 0", m_rd_en);
        end
        if (held < 0) begin
          held = m_raddr;
        end else begin
          checks++;
          if (m_raddr !== held) begin
            failures++;
            $display("FAIL stall_hold: raddr=%0d required %0d", m_raddr, held);
          end
        end
      end
      if (m_rd_en) begin
        if (held >= 0) begin
          checks++;
          if (m_raddr !== held) begin
            failures++;
            $display("FAIL stall_resume: raddr=%0d required %0d", m_raddr, held);
          end
          held = -1;
        end
        rd_q.push_back(m_raddr);
      end
      if (m_vld) n_vld++;
      if (m_first) begin n_first++; first_addr = prev; end
      if (m_last) begin n_last++; last_addr = prev; last_pos = n_vld; end
      prev = m_rd_en ? m_raddr : -1;
      if (m_busy) begin busy_seen = 1; idle = 0; end
      else if (busy_seen) idle++;
      if (busy_seen && idle >= 3) begin done_ok = 1; break; end
    end
    wrt_smpl = 1'b0;
    checks++;
    if (!done_ok) begin
      failures++;
      $display("FAIL collect_timeout: burst not completed within %0d cycles", max_cyc);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    checks++;
    if ({s_we, s_rd_en, s_vld, s_first, s_last, s_full, s_busy, s_ovr} !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags: we,rd_en,vld,first,last,full,busy,ovr=%b required 00000000",
               {s_we, s_rd_en, s_vld, s_first, s_last, s_full, s_busy, s_ovr});
    end
    checks++;
    if ({s_waddr, s_raddr} !== 8'h00) begin
      failures++;
      $display("FAIL reset_addr: waddr=%0d raddr=%0d required 0 0", s_waddr, s_raddr);
    end
    checks++;
    if ({b_full, b_busy, b_vld, b_ovr} !== 4'h0 || b_waddr !== 11'd0) begin
      failures++;
      $display("FAIL reset_big: full,busy,vld,ovr=%b waddr=%0d required 0000 0",
               {b_full, b_busy, b_vld, b_ovr}, b_waddr);
    end
  endtask

  task automatic test_first_burst();
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      wrt_smpl = 1'b1;
      dat_rdy = 1'b1;
      #1;
      checks++;
      if (s_we !== 1'b1 || s_waddr !== 4'(i) || s_full !== 1'b0) begin
        failures++;
        $display("FAIL write_%0d: we=%0b waddr=%0d full=%0b required 1 %0d 0", i, s_we, s_waddr, s_full, i);
      end
    end
    tick();
    wrt_smpl = 1'b0;
    #1;
    checks++;
    if (s_full !== 1'b1 || s_busy !== 1'b0 || s_rd_en !== 1'b0 || s_waddr !== 4'd5) begin
      failures++;
      $display("FAIL post_fill: full=%0b busy=%0b rd_en=%0b waddr=%0d required 1 0 0 5",
               s_full, s_busy, s_rd_en, s_waddr);
    end
    collect(30, -1, 0, 32'h0);
    checks++;
    if (rd_q.size() != 5 || rd_q[0] != 0 || rd_q[1] != 1 || rd_q[2] != 2 || rd_q[3] != 3 || rd_q[4] != 4) begin
      failures++;
      $display("FAIL first_raddr: got %p required 0 1 2 3 4", rd_q);
    end
    checks++;
    if (n_vld != 5 || n_first != 1 || n_last != 1 || first_addr != 0 || last_addr != 4 || last_pos != 5) begin
      failures++;
      $display("FAIL first_qual: vld=%0d first=%0d@%0d last=%0d@%0d pos=%0d required 5 1@0 1@4 pos 5",
               n_vld, n_first, first_addr, n_last, last_addr, last_pos);
    end
  endtask

  task automatic test_wrap();
    int exp_a[5] = '{14, 15, 0, 1, 2};
    int bad;
    sel = 1'b0;
    do_reset();
    write_n(18);
    collect(200, -1, 0, 32'h0);
    write_n(1);
    collect(30, -1, 0, 32'h0);
    bad = (rd_q.size() != 5) ? 1 : 0;
    for (int i = 0; i < 5 && bad == 0; i++) if (rd_q[i] != exp_a[i]) bad = 1;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wrap_raddr: got %p required 14 15 0 1 2", rd_q);
    end
    checks++;
    if (first_addr != 14 || last_addr != 2 || n_vld != 5 || s_full !== 1'b1) begin
      failures++;
      $display("FAIL wrap_qual: first@%0d last@%0d vld=%0d full=%0b required 14 2 5 1",
               first_addr, last_addr, n_vld, s_full);
    end
  endtask

  task automatic test_stall();
    sel = 1'b0;
    do_reset();
    write_n(5);
    collect(40, 2, 3, 32'h0);
    checks++;
    if (rd_q.size() != 5 || rd_q[0] != 0 || rd_q[1] != 1 || rd_q[2] != 2 || rd_q[3] != 3 || rd_q[4] != 4) begin
      failures++;
      $display("FAIL stall_raddr: got %p required 0 1 2 3 4", rd_q);
    end
    checks++;
    if (n_vld != 5 || n_first != 1 || n_last != 1) begin
      failures++;
      $display("FAIL stall_counts: vld=%0d first=%0d last=%0d required 5 1 1", n_vld, n_first, n_last);
    end
  endtask

  task automatic test_back_to_back();
    int exp_a[10] = '{0, 1, 2, 3, 4, 2, 3, 4, 5, 6};
    int bad;
    sel = 1'b0;
    do_reset();
    write_n(5);
    collect(60, -1, 0, 32'h0000_0014);
    bad = (rd_q.size() != 10) ? 1 : 0;
    for (int i = 0; i < 10 && bad == 0; i++) if (rd_q[i] != exp_a[i]) bad = 1;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_raddr: got %p required 0 1 2 3 4 2 3 4 5 6", rd_q);
    end
    checks++;
    if (n_vld != 10 || n_first != 2 || n_last != 2) begin
      failures++;
      $display("FAIL b2b_counts: vld=%0d first=%0d last=%0d required 10 2 2", n_vld, n_first, n_last);
    end
    checks++;
    if (s_ovr !== OVR_EXP) begin
      failures++;
      $display("FAIL overrun: overrun=%0b required %0b", s_ovr, OVR_EXP);
    end
    repeat (5) tick();
    checks++;
    if (s_ovr !== OVR_EXP) begin
      failures++;
      $display("FAIL overrun_sticky: overrun=%0b required %0b", s_ovr, OVR_EXP);
    end
  endtask

  task automatic test_reset_mid();
    bit busy_seen;
    sel = 1'b0;
    do_reset();
    write_n(5);
    tick();
    wrt_smpl = 1'b0;
    dat_rdy = 1'b1;
    repeat (4) tick();
    checks++;
    if (s_rd_en !== 1'b1 || s_raddr !== 4'd3) begin
      failures++;
      $display("FAIL mid_idx3: rd_en=%0b raddr=%0d required 1 3", s_rd_en, s_raddr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_rd_en, s_vld, s_first, s_last, s_full, s_busy, s_ovr} !== 7'h00 ||
        s_raddr !== 4'd0 || s_waddr !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset: rd_en,vld,first,last,full,busy,ovr=%b raddr=%0d waddr=%0d required 0000000 0 0",
               {s_rd_en, s_vld, s_first, s_last, s_full, s_busy, s_ovr}, s_raddr, s_waddr);
    end
    tick();
    checks++;
    if (s_vld !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_vld: dat_vld=%0b required 0", s_vld);
    end
    rst_n = 1'b1;
    write_n(4);
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      wrt_smpl = 1'b0;
      #1;
      if (s_busy) busy_seen = 1;
    end
    checks++;
    if (busy_seen || s_full !== 1'b0) begin
      failures++;
      $display("FAIL mid_refill: busy_seen=%0b full=%0b required 0 0", busy_seen, s_full);
    end
    write_n(1);
    collect(30, -1, 0, 32'h0);
    checks++;
    if (rd_q.size() != 5 || rd_q[0] != 0 || rd_q[4] != 4 || n_vld != 5) begin
      failures++;
      $display("FAIL mid_reburst: got %p vld=%0d required 0 1 2 3 4 and 5", rd_q, n_vld);
    end
  endtask

  task automatic test_default_params();
    int bad_idx;
    sel = 1'b1;
    do_reset();
    write_n(1021);
    collect(1200, -1, 0, 32'h0);
    checks++;
    if (rd_q.size() != 1021 || rd_q[0] != 0 || b_full !== 1'b1) begin
      failures++;
      $display("FAIL big_first: reads=%0d start=%0d full=%0b required 1021 0 1",
               rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : -1, b_full);
    end
    write_n(1);
    collect(1200, -1, 0, 32'h0);
    bad_idx = (rd_q.size() != 1021) ? 0 : -1;
    for (int i = 0; i < rd_q.size() && bad_idx < 0; i++) if (rd_q[i] != (1 + i) % 1536) bad_idx = i;
    checks++;
    if (bad_idx >= 0) begin
      failures++;
      $display("FAIL big_raddr: reads=%0d first bad index %0d required 1021 reads from 1", rd_q.size(), bad_idx);
    end
    checks++;
    if (n_vld != 1021 || n_first != 1 || n_last != 1 || first_addr != 1 || last_addr != 1021 || last_pos != 1021) begin
      failures++;
      $display("FAIL big_qual: vld=%0d first=%0d@%0d last=%0d@%0d pos=%0d required 1021 1@1 1@1021 1021",
               n_vld, n_first, first_addr, n_last, last_addr, last_pos);
    end
    sel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wrt_smpl = 1'b0;
    dat_rdy = 1'b0;
    test_reset();
    test_first_burst();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_default_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
